// File: rtl/out_display_pkg.sv
// ============================================================================
// out_display_pkg: converter state encoding, segment codes, digit-count helper
// Revision 1.0
// ============================================================================
`default_nettype none

package out_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // ceil(width * log10(2)) using a fixed-point log10(2) = 0.30103
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/out_display_ctrl_bin2bcd.sv
// ============================================================================
// bin2bcd_seq: iterative double-dabble converter, one bit per clock
// Revision 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import out_display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  mclk,
    input  logic                  i_reset,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  o_busy,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t          state;
    conv_state_t          state_next;
    logic [WIDTH-1:0]     shift_reg;
    logic [WIDTH-1:0]     captured;
    logic [WIDTH-1:0]     last_value;
    logic [4*DIGITS-1:0]  acc;
    logic [4*DIGITS-1:0]  acc_adj;
    logic [CNT_W-1:0]     count;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_data != last_value) state_next = SHIFT;
            SHIFT:   if (count == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // captured keeps the converted value intact while shift_reg is consumed
    always_ff @(posedge mclk or posedge i_reset) begin
        if (i_reset) begin
            shift_reg  <= '0;
            captured   <= '0;
            last_value <= '0;
            acc        <= '0;
            count      <= '0;
            o_busy     <= 1'b0;
            o_bcd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_data != last_value) begin
                        shift_reg <= i_data;
                        captured  <= i_data;
                        acc       <= '0;
                        count     <= CNT_W'(WIDTH);
                        o_busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    {acc, shift_reg} <= {acc_adj, shift_reg} << 1;
                    count            <= count - 1'b1;
                end
                DONE: begin
                    o_bcd      <= acc;
                    last_value <= captured;
                    o_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/out_display_ctrl.sv
// ============================================================================
// out_display_ctrl: binary value to multiplexed active-low 7-segment display
// Revision 1.0
// ============================================================================
`default_nettype none

module out_display_ctrl
    import out_display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 1024
) (
    input  logic                  mclk,
    input  logic                  i_reset,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  o_busy,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_anode,
    output logic [6:0]            o_seg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]   refresh_cnt;
    logic               refresh_wrap;
    logic [IDX_W-1:0]   digit_idx;
    logic [IDX_W-1:0]   idx_next;
    logic [DIGITS-1:0]  blank;
    logic [DIGITS-1:0]  anode_next;
    logic [3:0]         nib_sel;
    logic               blank_sel;
    logic [6:0]         seg_next;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .mclk    (mclk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .o_busy  (o_busy),
        .o_bcd   (o_bcd)
    );

    assign refresh_wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        idx_next = digit_idx;
        if (refresh_wrap) begin
            idx_next = (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end
    end

    // A digit is blanked when it and every digit above it are zero
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_lsd
            assign blank[i] = 1'b0;
        end else begin : g_upper
            assign blank[i] = (o_bcd[4*DIGITS-1:4*i] == '0);
        end
    end

    always_comb begin
        nib_sel    = '0;
        blank_sel  = 1'b0;
        anode_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                nib_sel       = o_bcd[4*i +: 4];
                blank_sel     = blank[i];
                anode_next[i] = 1'b0;
            end
        end
        seg_next = blank_sel ? SEG_BLANK : seg_code(nib_sel);
    end

    always_ff @(posedge mclk or posedge i_reset) begin
        if (i_reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            o_anode     <= ~DIGITS'(1);
            o_seg       <= SEG_0;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            digit_idx   <= idx_next;
            o_anode     <= anode_next;
            o_seg       <= seg_next;
        end
    end

endmodule

`default_nettype wire

// File: doc/out_display_ctrl.md
# out_display_ctrl

Sequencer that turns the SAP-1 output register value into a multiplexed, active-low 7-segment display. It watches the binary value driven by the output register. When the value changes, it runs an iterative double-dabble binary-to-BCD conversion and latches the resulting digits. It then time-multiplexes one digit at a time onto shared segment lines. It sits between the output register's data bus and the FPGA display pins, and runs on the raw system clock so the display stays live while the CPU is halted.

## Interface
- WIDTH, 8, width of the binary value to display
- DIGITS, 3, number of display digits; must satisfy DIGITS >= ceil(WIDTH*log10(2))
- REFRESH_DIV, 1024, mclk cycles each digit is held active; must be >= 2

- mclk  input  1  system clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_data  input  WIDTH  binary value from the output register
- o_busy  output  1  conversion in progress
- o_bcd  output  4*DIGITS  latched BCD value, digit 0 in bits [3:0]
- o_anode  output  DIGITS  digit select, active-low one-hot
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Converter FSM states: IDLE, SHIFT, DONE.
- IDLE: if i_data != last_value, capture i_data into the shift register, clear the BCD accumulator, load count = WIDTH, set o_busy, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT, one bit per mclk:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, shift} shifts left by 1.
  - count decrements by 1.
  - When count reaches 0, go to DONE.
- DONE: copy the accumulator to o_bcd, set last_value = captured value, clear o_busy, and go to IDLE.
- i_data changes during SHIFT/DONE are ignored. The IDLE comparison on return picks up the new value and starts a new conversion, so the final o_bcd always matches the final stable i_data.
- Scan:
  - A refresh counter runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0..DIGITS-1 and wraps to 0.
  - o_anode and o_seg are registered decodes of the (next index, o_bcd) pair. They change on the same edge as the index.
- Segment codes (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Leading-zero blanking: digit i > 0 shows blank if it and every higher digit are 0. Digit 0 is never blanked.
- Nibble values above 9 cannot occur. The decoder maps them to blank.

## Timing
- Reset values (asynchronous, while i_reset is high):
  - state=IDLE, last_value=0, o_bcd=0, o_busy=0.
  - refresh counter=0, index=0.
  - o_anode = all ones except bit 0, e.g. 3'b110.
  - o_seg = 7'h40.
- Reset mid-SHIFT aborts the conversion. After release, i_data != 0 restarts conversion from IDLE.
- Conversion latency, with i_data changed before edge N:
  - Capture at edge N; o_busy high after edge N.
  - Shifts at edges N+1..N+WIDTH.
  - o_bcd updates and o_busy falls at edge N+WIDTH+1.
  - Total WIDTH+2 cycles from the change to the next possible capture.
- o_bcd changes only in DONE. The displayed digits never show a partial conversion.
- Digit dwell is exactly REFRESH_DIV cycles. A full scan takes DIGITS*REFRESH_DIV cycles.
- A new o_bcd is reflected on o_seg at the first edge after the DONE edge.

## Structure
- Package out_display_pkg holds:
  - Converter state enum.
  - Segment code constants and the blank code.
  - Function computing the minimum DIGITS from WIDTH.
- Sub-module bin2bcd_seq holds:
  - The IDLE/SHIFT/DONE FSM, shift register, BCD accumulator, count, last_value and o_busy.
  - Its ports are mclk, i_reset, i_data, o_busy and o_bcd.
- The top level holds the refresh counter, digit index, blanking logic and segment decoder.

## Test plan
- Reset, then hold i_data=0: o_bcd=12'h000 and o_busy=0 indefinitely. o_anode cycles 110→101→011 every 1024 cycles. o_seg=7'h40 on digit 0 and 7'h7F on digits 1–2.
- i_data=8'd255 before edge N: o_busy=1 for edges N..N+8, o_bcd=12'h255 at edge N+9, and the scan shows segments 12, 12, 24 on digits 0, 1, 2.
- i_data=8'd7: digits 2 and 1 show 7'h7F, digit 0 shows 7'h78. i_data=8'd105: digit 1 shows 7'h40 (not blanked), digit 2 shows 7'h79.
- i_data=12, then 200 two cycles later (mid-SHIFT): o_bcd becomes 12'h012, then 12'h200 exactly WIDTH+2 cycles after the first DONE.
- Assert i_reset during SHIFT of a 255 conversion: all outputs return to reset values immediately. Release with i_data=255: o_bcd=12'h255 after WIDTH+2 cycles.
- Use REFRESH_DIV=2 and DIGITS=3: o_anode changes every 2 cycles and wraps from 011 to 110.
